// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: widths, opcode
// constants, instruction field positions, fetch FSM states and payload type.
package fetch_unit_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned INST_W = 16;
   localparam int unsigned OP_W   = 4;

   localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

   localparam logic [OP_W-1:0] OP_HALT = 4'b1100;
   localparam logic [OP_W-1:0] OP_BEQZ = 4'b1001;
   localparam logic [OP_W-1:0] HALT_OP = OP_HALT;

   localparam int unsigned OP_MSB  = 15;
   localparam int unsigned OP_LSB  = 12;
   localparam int unsigned RD_MSB  = 11;
   localparam int unsigned RD_LSB  = 8;
   localparam int unsigned RS_MSB  = 7;
   localparam int unsigned RS_LSB  = 4;
   localparam int unsigned IMM_MSB = 3;
   localparam int unsigned IMM_LSB = 0;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_HALTED
   } state_e;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [ADDR_W-1:0] pc;
   } fetch_pkt_t;

   function automatic logic [OP_W-1:0] opcode(input logic [INST_W-1:0] inst);
      return inst[OP_MSB:OP_LSB];
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, decode handshake, execute
// redirect and halt status. master = fetch unit, slave = its environment.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic [ADDR_W-1:0] inst_addr;
   logic [INST_W-1:0] inst_data;
   logic              f_valid;
   logic              f_ready;
   logic [INST_W-1:0] f_inst;
   logic [ADDR_W-1:0] f_pc;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              halted;

   modport master (
      output inst_addr, f_valid, f_inst, f_pc, halted,
      input  inst_data, f_ready, redirect, redirect_pc
   );

   modport slave (
      input  inst_addr, f_valid, f_inst, f_pc, halted,
      output inst_data, f_ready, redirect, redirect_pc
   );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches from combinational instruction
// memory into a valid/ready fetch register, handles redirects and halt.
module fetch_unit
   import fetch_unit_pkg::*;
(
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   fetch_pkt_t        fetch_q, fetch_d;
   logic              valid_q, valid_d;
   logic              halted_q, halted_d;

   logic load_c;
   logic accept_c;
   logic is_halt_c;

   assign load_c    = (state_q == ST_RUN) && (!valid_q || bus.f_ready) && !bus.redirect;
   assign accept_c  = valid_q && bus.f_ready;
   assign is_halt_c = (opcode(bus.inst_data) == HALT_OP);

   // Next-state logic; a redirect overrides everything and discards the fetch register
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      fetch_d  = fetch_q;
      valid_d  = valid_q;
      halted_d = halted_q;
      if (bus.redirect) begin
         pc_d     = bus.redirect_pc;
         valid_d  = 1'b0;
         halted_d = 1'b0;
         state_d  = ST_RUN;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (load_c) begin
                  fetch_d = '{inst: bus.inst_data, pc: pc_q};
                  valid_d = 1'b1;
                  pc_d    = pc_q + ADDR_W'(1);
                  if (is_halt_c) state_d = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (accept_c) begin
                  valid_d  = 1'b0;
                  halted_d = 1'b1;
                  state_d  = ST_HALTED;
               end
            end
            ST_HALTED: begin
               valid_d  = 1'b0;
               halted_d = 1'b1;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) pc_q <= RESET_PC;
      else     pc_q <= pc_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_q <= '0;
         valid_q <= 1'b0;
      end else begin
         fetch_q <= fetch_d;
         valid_q <= valid_d;
      end
   end

   assign bus.inst_addr = pc_q;
   assign bus.f_valid   = valid_q;
   assign bus.f_inst    = fetch_q.inst;
   assign bus.f_pc      = fetch_q.pc;
   assign bus.halted    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected instruction stream rebuilt from
// memory on every reset/redirect, popped as decode accepts words.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fetch_unit_if bus();

   fetch_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [INST_W-1:0] mem [0:255];
   assign bus.inst_data = mem[bus.inst_addr];

   int checks   = 0;
   int failures = 0;
   int n_accept = 0;

   fetch_pkt_t        exp_q[$];
   fetch_pkt_t        e;
   logic              fv_exp      = 1'b0;
   logic              halted_exp  = 1'b0;
   logic              after_rst   = 1'b0;
   logic              addr_chk_en = 1'b0;
   logic [ADDR_W-1:0] addr_exp    = '0;
   logic [ADDR_W-1:0] halt_addr   = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
      end
   endtask

   // Program order from address t up to and including the first halt word
   task automatic restart(input logic [ADDR_W-1:0] t);
      logic [ADDR_W-1:0] a;
      a = t;
      exp_q.delete();
      for (int k = 0; k < 1024; k++) begin
         exp_q.push_back('{inst: mem[a], pc: a});
         if (mem[a][15:12] == OP_HALT) break;
         a = a + ADDR_W'(1);
      end
   endtask

   // Monitor: state committed at the last posedge is visible here; inputs now
   // present decide what the next posedge does.
   always @(negedge clk) begin
      if (rst) begin
         restart(RESET_PC);
         fv_exp      = 1'b0;
         halted_exp  = 1'b0;
         after_rst   = 1'b1;
         addr_chk_en = 1'b1;
         addr_exp    = RESET_PC;
      end else begin
         chk("f_valid", 32'(bus.f_valid), 32'(fv_exp));
         chk("halted", 32'(bus.halted), 32'(halted_exp));
         if (after_rst) begin
            chk("rst_f_inst", 32'(bus.f_inst), 32'd0);
            chk("rst_f_pc", 32'(bus.f_pc), 32'd0);
         end
         if (addr_chk_en) chk("inst_addr", 32'(bus.inst_addr), 32'(addr_exp));
         after_rst   = 1'b0;
         addr_chk_en = 1'b0;
         if (halted_exp) begin
            addr_chk_en = 1'b1;
            addr_exp    = halt_addr;
         end
         if (bus.redirect) begin
            restart(bus.redirect_pc);
            fv_exp      = 1'b0;
            halted_exp  = 1'b0;
            addr_chk_en = 1'b1;
            addr_exp    = bus.redirect_pc;
         end else if (bus.f_valid && bus.f_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_underflow: got pc %0h expected no word at t=%0t", bus.f_pc, $time);
            end else begin
               e = exp_q.pop_front();
               n_accept++;
               chk("f_inst", 32'(bus.f_inst), 32'(e.inst));
               chk("f_pc", 32'(bus.f_pc), 32'(e.pc));
               if (e.inst[15:12] == OP_HALT) begin
                  halted_exp  = 1'b1;
                  fv_exp      = 1'b0;
                  halt_addr   = e.pc + ADDR_W'(1);
                  addr_chk_en = 1'b1;
                  addr_exp    = halt_addr;
               end else begin
                  fv_exp = 1'b1;
               end
            end
         end else begin
            fv_exp = !halted_exp;
         end
      end
   end

   task automatic drive(input logic rdy, input logic rd, input logic [ADDR_W-1:0] rpc, input logic r);
      rst             = r;
      bus.f_ready     = rdy;
      bus.redirect    = rd;
      bus.redirect_pc = rpc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] w;
      bus.f_ready     = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h5000 | 16'(i);
      mem[0] = 16'h4103;
      mem[1] = 16'h4200;
      mem[2] = 16'h4301;
      mem[9] = 16'hC030;
      drive(1'b0, 1'b0, '0, 1'b1);
      drive(1'b0, 1'b0, '0, 1'b1);

      // Startup, three-cycle stall at pc 1, then redirect to 3 during a handshake
      drive(1'b1, 1'b0, '0, 1'b0);
      drive(1'b1, 1'b0, '0, 1'b0);
      repeat (3) drive(1'b0, 1'b0, '0, 1'b0);
      drive(1'b1, 1'b0, '0, 1'b0);
      drive(1'b1, 1'b1, 8'h03, 1'b0);
      // Run through the halt at 9 and stay frozen
      repeat (20) drive(1'b1, 1'b0, '0, 1'b0);
      // Halt held in the fetch register, then cancelled by redirect to 4
      drive(1'b1, 1'b1, 8'h08, 1'b0);
      drive(1'b1, 1'b0, '0, 1'b0);
      drive(1'b1, 1'b0, '0, 1'b0);
      repeat (2) drive(1'b0, 1'b0, '0, 1'b0);
      drive(1'b0, 1'b1, 8'h04, 1'b0);
      repeat (4) drive(1'b1, 1'b0, '0, 1'b0);
      // PC wrap from 8'hFF to 8'h00, then reset during a stall
      drive(1'b1, 1'b1, 8'hFF, 1'b0);
      repeat (4) drive(1'b1, 1'b0, '0, 1'b0);
      repeat (2) drive(1'b0, 1'b0, '0, 1'b0);
      drive(1'b0, 1'b0, '0, 1'b1);
      repeat (3) drive(1'b1, 1'b0, '0, 1'b0);

      // Randomized programs, backpressure, redirects and occasional resets
      for (int blk = 0; blk < 4; blk++) begin
         drive(1'b0, 1'b0, '0, 1'b1);
         for (int i = 0; i < 256; i++) begin
            w = $urandom;
            if ($urandom_range(0, 31) == 0) w[15:12] = OP_HALT;
            else if (w[15:12] == OP_HALT) w[15:12] = 4'h0;
            mem[i] = w[15:0];
         end
         drive(1'b0, 1'b0, '0, 1'b1);
         for (int c = 0; c < 500; c++) begin
            drive(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 4),
                  ADDR_W'($urandom), ($urandom_range(0, 199) == 0));
         end
      end

      checks++;
      if (n_accept < 200) begin
         failures++;
         $display("FAIL progress: got %0d accepted words required at least 200", n_accept);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
